// File: rtl/fdma_arb_pkg.sv
// Shared types for the FDMA port arbiter: FSM state enum and
// a helper that sizes channel-index fields from the channel count.
package fdma_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2
  } arb_state_e;

  // CH_IDX_W helper: $clog2(n), never below 1 bit
  function automatic int ch_idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fdma_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Ports: i_req (request vector), i_ptr (last served index),
// o_valid (any request), o_idx (first request after i_ptr).
module rr_pick
  import fdma_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = ch_idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);

  // Walk from the farthest candidate to the nearest so the
  // closest request after i_ptr is the one left standing.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int k = N; k >= 1; k--) begin
      int c;
      c = (int'(i_ptr) + k) % N;
      if (i_req[c]) begin
        o_valid = 1'b1;
        o_idx   = IW'(c);
      end
    end
  end

endmodule

// File: rtl/fdma_port_arbiter.sv
// fdma_port_arbiter: shares one FDMA master among NUM_CH requesters,
// round-robin per burst; addr/size latched at grant, beats steered.
// Ports: ui_clk/ui_rst, ch_* (per-channel flat buses, ch0 in LSBs),
// m_* (FDMA master side), grant_id, wdog_err.
// Option: define FDMA_ARB_WDOG_EN to enable the m_areq->m_busy watchdog.
module fdma_port_arbiter
  import fdma_arb_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 128,
  parameter int SIZE_W   = 16,
  parameter int WDOG_CYC = 1024
) (
  input  logic                       ui_clk,
  input  logic                       ui_rst,
  input  logic [NUM_CH-1:0]          ch_areq,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH*SIZE_W-1:0]   ch_size,
  output logic [NUM_CH-1:0]          ch_busy,
  input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
  input  logic [NUM_CH-1:0]          ch_ready,
  output logic [NUM_CH-1:0]          ch_valid,
  output logic                       m_areq,
  output logic [ADDR_W-1:0]          m_addr,
  output logic [SIZE_W-1:0]          m_size,
  input  logic                       m_busy,
  output logic [DATA_W-1:0]          m_wdata,
  output logic                       m_ready,
  input  logic                       m_valid,
  output logic [$clog2(NUM_CH)-1:0]  grant_id,
  output logic                       wdog_err
);

  localparam int IW = ch_idx_w(NUM_CH);

  if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_ch
    $error("NUM_CH must be 2..8");
  end
  if (WDOG_CYC < 1) begin : g_bad_wdog
    $error("WDOG_CYC must be >= 1");
  end

  arb_state_e          r_state;
  logic [IW-1:0]       r_ptr;
  logic [IW-1:0]       r_grant;
  logic                r_areq;
  logic [ADDR_W-1:0]   r_addr;
  logic [SIZE_W-1:0]   r_size;
  logic [NUM_CH-1:0]   r_busy;

  logic                w_win_vld;
  logic [IW-1:0]       w_win;
  logic [NUM_CH-1:0]   w_oh_win;
  logic [NUM_CH-1:0]   w_oh_grant;
  logic                w_active;

  logic [ADDR_W-1:0]   w_addr  [NUM_CH];
  logic [SIZE_W-1:0]   w_size  [NUM_CH];
  logic [DATA_W-1:0]   w_wdata [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign w_addr[g]  = ch_addr[g*ADDR_W +: ADDR_W];
    assign w_size[g]  = ch_size[g*SIZE_W +: SIZE_W];
    assign w_wdata[g] = ch_wdata[g*DATA_W +: DATA_W];
  end

  rr_pick #(.N(NUM_CH), .IW(IW)) u_pick (
    .i_req   (ch_areq),
    .i_ptr   (r_ptr),
    .o_valid (w_win_vld),
    .o_idx   (w_win)
  );

  assign w_oh_win   = {{(NUM_CH-1){1'b0}}, 1'b1} << w_win;
  assign w_oh_grant = {{(NUM_CH-1){1'b0}}, 1'b1} << r_grant;
  assign w_active   = (r_state != S_IDLE);

`ifdef FDMA_ARB_WDOG_EN
  localparam int WDW = $clog2(WDOG_CYC + 1);
  logic [WDW-1:0] r_wdog_cnt;
  logic           r_wdog_err;
`endif

  always_ff @(posedge ui_clk or posedge ui_rst) begin
    if (ui_rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= IW'(NUM_CH - 1);
      r_grant    <= '0;
      r_areq     <= 1'b0;
      r_addr     <= '0;
      r_size     <= '0;
      r_busy     <= '0;
`ifdef FDMA_ARB_WDOG_EN
      r_wdog_cnt <= '0;
      r_wdog_err <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          // engine still busy from the last burst: hold off
          if (!m_busy && w_win_vld) begin
            r_grant <= w_win;
            r_addr  <= w_addr[w_win];
            r_size  <= w_size[w_win];
            r_areq  <= 1'b1;
            r_busy  <= w_oh_win;
            r_state <= S_REQ;
`ifdef FDMA_ARB_WDOG_EN
            r_wdog_cnt <= '0;
`endif
          end
        end
        S_REQ: begin
          if (m_busy) begin
            r_areq  <= 1'b0;
            r_state <= S_XFER;
          end
`ifdef FDMA_ARB_WDOG_EN
          else if (r_wdog_cnt == WDW'(WDOG_CYC - 1)) begin
            r_areq     <= 1'b0;
            r_busy     <= '0;
            r_wdog_err <= 1'b1;
            r_ptr      <= r_grant;
            r_state    <= S_IDLE;
          end else begin
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
          end
`endif
        end
        S_XFER: begin
          if (!m_busy) begin
            r_busy  <= '0;
            r_ptr   <= r_grant;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_areq   = r_areq;
  assign m_addr   = r_addr;
  assign m_size   = r_size;
  assign ch_busy  = r_busy;
  assign grant_id = r_grant;
  assign m_wdata  = w_wdata[r_grant];
  assign m_ready  = w_active & ch_ready[r_grant];
  assign ch_valid = (w_active && m_valid) ? w_oh_grant : '0;

`ifdef FDMA_ARB_WDOG_EN
  assign wdog_err = r_wdog_err;
`else
  assign wdog_err = 1'b0;
`endif

endmodule
